button_conditioner: RTL

Front-end stage for the three game buttons (red, blue, yellow) that drives the menu/play state controller.
- Per button: two-flop synchronizes the raw pad input, debounces it, and emits clean single-cycle press/release pulses plus optional auto-repeat pulses for held scroll buttons.
- The state controller consumes only btn_press/btn_event and never samples raw pads.

---
 rtl/button_conditioner_pkg.sv | 27 ++
 rtl/button_channel.sv | 134 +++++++++++++
 rtl/button_conditioner.sv | 58 +++++
 3 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the game-button front end: channel indices,
// channel count, board-clock timing defaults and the repeat FSM states.
package button_conditioner_pkg;

  // Button channel indices, also used by the menu/play state controller
  localparam int BTN_RED    = 0;
  localparam int BTN_BLUE   = 1;
  localparam int BTN_YELLOW = 2;

  localparam int N_BTN = 3;

  // Board-clock timing defaults
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 10000000;

  // Red and blue scroll with auto-repeat; yellow confirms and never repeats
  localparam logic [N_BTN-1:0] DEF_REPEAT_MASK = 3'b011;
  localparam bit               DEF_ACTIVE_LOW  = 1'b0;

  // Auto-repeat FSM states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } rep_state_e;

endpackage

// File: rtl/button_channel.sv
// One button channel: two-flop synchronizer, debounce filter, registered
// press/release pulses and an optional auto-repeat FSM.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN       = 1'b1,
  parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt,
  output logic ev,
  output logic press_nxt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  // Reload value so that repeats after the first are REPEAT_PERIOD apart
  localparam int RELOAD = (REPEAT_DELAY > REPEAT_PERIOD) ? (REPEAT_DELAY - REPEAT_PERIOD) : 0;

  logic          sync1_r;
  logic          sync2_r;
  logic          db_level_r;
  logic [CW-1:0] cnt_r;
  logic          level_r;
  logic          press_r;
  logic          rel_r;
  logic          rpt_r;
  logic          ev_r;
  rep_state_e    state_r;
  logic [HW-1:0] hc_r;

  logic s_s;
  logic rise_s;
  logic fall_s;
  logic rpt_fire_s;

  // Polarity correction happens after synchronization so the pad stays a plain bit
  assign s_s    = sync2_r ^ ACTIVE_LOW;
  assign rise_s = db_level_r & ~level_r;
  assign fall_s = ~db_level_r & level_r;

  // A repeat fires only while holding, and never in a release cycle
  assign rpt_fire_s = REPEAT_EN && (state_r == ST_HOLD) && !fall_s &&
                      (hc_r == HW'(REPEAT_DELAY - 1));

  // Synchronize the pad and filter it: the level flips only after a run of differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      db_level_r <= 1'b0;
      cnt_r      <= '0;
    end else begin
      sync1_r <= pad;
      sync2_r <= sync1_r;
      if (s_s == db_level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_level_r <= ~db_level_r;
        cnt_r      <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Register the debounced level and its edge pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      level_r <= 1'b0;
      press_r <= 1'b0;
      rel_r   <= 1'b0;
      ev_r    <= 1'b0;
    end else begin
      level_r <= db_level_r;
      press_r <= rise_s;
      rel_r   <= fall_s;
      ev_r    <= rise_s | rpt_fire_s;
    end
  end

  // Auto-repeat FSM: arm on press, count while held, disarm on release
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      hc_r    <= '0;
      rpt_r   <= 1'b0;
    end else begin
      rpt_r <= rpt_fire_s;
      case (state_r)
        ST_IDLE: begin
          hc_r <= '0;
          if (REPEAT_EN && rise_s) begin
            state_r <= ST_HOLD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (fall_s) begin
            state_r <= ST_IDLE;
            hc_r    <= '0;
          end else if (hc_r == HW'(REPEAT_DELAY - 1)) begin
            state_r <= ST_HOLD;
            hc_r    <= HW'(RELOAD);
          end else begin
            state_r <= ST_HOLD;
            hc_r    <= hc_r + HW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          hc_r    <= '0;
        end
      endcase
    end
  end

  assign level     = level_r;
  assign press     = press_r;
  assign rel       = rel_r;
  assign rpt       = rpt_r;
  assign ev        = ev_r;
  assign press_nxt = rise_s;

endmodule

// File: rtl/button_conditioner.sv
// Front end for the red/blue/yellow game buttons: one independent
// conditioning channel per button plus a registered any-press flag.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int               N_BTN           = button_conditioner_pkg::N_BTN,
  parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int               REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int               REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = DEF_REPEAT_MASK,
  parameter bit               BTN_ACTIVE_LOW  = DEF_ACTIVE_LOW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic [N_BTN-1:0] btn_event,
  output logic             any_press
);

  logic [N_BTN-1:0] press_nxt_s;
  logic             any_press_r;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i]),
      .ACTIVE_LOW      (BTN_ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .pad       (btn_raw[i]),
      .level     (btn_level[i]),
      .press     (btn_press[i]),
      .rel       (btn_release[i]),
      .rpt       (btn_repeat[i]),
      .ev        (btn_event[i]),
      .press_nxt (press_nxt_s[i])
    );
  end

  // Register the OR of next-cycle presses so any_press aligns with btn_press
  always_ff @(posedge clk) begin
    if (rst) begin
      any_press_r <= 1'b0;
    end else begin
      any_press_r <= |press_nxt_s;
    end
  end

  assign any_press = any_press_r;

endmodule
